// File: rtl/uart_rx2.sv
`timescale 1ns / 1ps
// uart_rx2: 8N1 UART receiver, LSB first, centre-sampled.
// Ports:
//   CLK       - system clock
//   RST_N     - asynchronous active-low reset
//   RX_DATA   - asynchronous serial line, idles high
//   RX_DV     - one-cycle strobe, RX_BYTE newly updated
//   RX_BYTE   - last good byte, held until the next good frame
//   FRAME_ERR - one-cycle strobe, stop bit sampled low
//   BUSY      - high while a frame is being received
module uart_rx2 #(
   parameter int unsigned F_CLK     = 50_000_000,
   parameter int unsigned UART_BAUD = 921600
) (
   input  logic       CLK,
   input  logic       RST_N,
   input  logic       RX_DATA,
   output logic       RX_DV,
   output logic [7:0] RX_BYTE,
   output logic       FRAME_ERR,
   output logic       BUSY
);

   localparam int unsigned CPB   = F_CLK / UART_BAUD;
   localparam int unsigned HALF  = CPB / 2;
   localparam int unsigned CNT_W = $clog2(CPB);

   generate
      if (CPB < 4) begin : g_cpb_check
         $error("uart_rx2: F_CLK/UART_BAUD must be at least 4");
      end
   endgenerate

   typedef enum logic [2:0] {
      WAIT_IDLE = 3'd0,
      IDLE      = 3'd1,
      START     = 3'd2,
      DATA      = 3'd3,
      STOP      = 3'd4
   } state_t;

   state_t             state;
   state_t             state_nxt;
   logic               sync_1;
   logic               rx_s;
   logic [CNT_W-1:0]   cnt;
   logic [CNT_W-1:0]   cnt_nxt;
   logic [2:0]         idx;
   logic [2:0]         idx_nxt;
   logic [7:0]         shreg;
   logic [7:0]         shreg_nxt;
   logic               dv_nxt;
   logic               ferr_nxt;
   logic [7:0]         byte_nxt;
   logic               busy_nxt;

   logic               cnt_half;
   logic               cnt_full;
   logic               sync_primed;

   assign cnt_half    = (cnt == CNT_W'(HALF - 1));
   assign cnt_full    = (cnt == CNT_W'(CPB - 1));
   // The synchroniser resets to 1, so its first two outputs after reset do
   // not reflect the line; WAIT_IDLE counts them off before trusting rx_s.
   assign sync_primed = (cnt == CNT_W'(2));

   // Two-flop synchroniser for the asynchronous line.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         sync_1 <= 1'b1;
         rx_s   <= 1'b1;
      end else begin
         sync_1 <= RX_DATA;
         rx_s   <= sync_1;
      end
   end

   // State register.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) state <= WAIT_IDLE;
      else        state <= state_nxt;
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state;
      unique case (state)
         WAIT_IDLE: if (sync_primed && rx_s) state_nxt = IDLE;
         IDLE:      if (!rx_s) state_nxt = START;
         START:     if (cnt_half) state_nxt = rx_s ? IDLE : DATA;
         DATA:      if (cnt_full && (idx == 3'd7)) state_nxt = STOP;
         STOP:      if (cnt_full) state_nxt = rx_s ? IDLE : WAIT_IDLE;
         default:   state_nxt = WAIT_IDLE;
      endcase
   end

   // Datapath and output next values.
   always_comb begin
      cnt_nxt   = cnt;
      idx_nxt   = idx;
      shreg_nxt = shreg;
      dv_nxt    = 1'b0;
      ferr_nxt  = 1'b0;
      byte_nxt  = RX_BYTE;
      unique case (state)
         WAIT_IDLE: begin
            if (!sync_primed) cnt_nxt = cnt + CNT_W'(1);
         end
         IDLE: begin
            cnt_nxt = '0;
         end
         START: begin
            cnt_nxt = cnt + CNT_W'(1);
            if (cnt_half) begin
               cnt_nxt = '0;
               idx_nxt = '0;
            end
         end
         DATA: begin
            cnt_nxt = cnt + CNT_W'(1);
            if (cnt_full) begin
               cnt_nxt        = '0;
               shreg_nxt[idx] = rx_s;
               idx_nxt        = idx + 3'd1;
            end
         end
         STOP: begin
            cnt_nxt = cnt + CNT_W'(1);
            if (cnt_full) begin
               cnt_nxt = '0;
               if (rx_s) begin
                  dv_nxt   = 1'b1;
                  byte_nxt = shreg;
               end else begin
                  ferr_nxt = 1'b1;
               end
            end
         end
         default: begin
            cnt_nxt = '0;
         end
      endcase
      busy_nxt = (state_nxt == START) || (state_nxt == DATA) || (state_nxt == STOP);
   end

   // Datapath and registered outputs.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         cnt       <= '0;
         idx       <= '0;
         shreg     <= '0;
         RX_DV     <= 1'b0;
         FRAME_ERR <= 1'b0;
         RX_BYTE   <= 8'h00;
         BUSY      <= 1'b0;
      end else begin
         cnt       <= cnt_nxt;
         idx       <= idx_nxt;
         shreg     <= shreg_nxt;
         RX_DV     <= dv_nxt;
         FRAME_ERR <= ferr_nxt;
         RX_BYTE   <= byte_nxt;
         BUSY      <= busy_nxt;
      end
   end

endmodule
